// File: rtl/sl28_wdt_pkg.sv
// Shared definitions for the SL28 watchdog: CTRL bit positions, register
// offsets within the decoded window, the kick magic default and FSM encoding.
package sl28_wdt_pkg;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_LOCK    = 1;
  localparam int CTRL_RST_EN  = 2;
  localparam int CTRL_EXPIRED = 7;

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_TIMEOUT = 2'd1;
  localparam logic [1:0] OFF_KICK    = 2'd2;
  localparam logic [1:0] OFF_COUNT   = 2'd3;

  localparam logic [7:0] KICK_MAGIC_DEF = 8'h6b;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_EXPIRED  = 2'd2
  } wdt_state_e;

endpackage

// File: rtl/sl28_wdt.sv
// SL28 watchdog: CSR window of four registers, a tick-driven countdown and an
// expiry FSM that raises a level irq and an optional one-cycle reset request.
module sl28_wdt
  import sl28_wdt_pkg::*;
#(
  parameter logic [7:0] BASE            = 8'h10,
  parameter logic [7:0] DEFAULT_TIMEOUT = 8'd30,
  parameter logic [7:0] KICK_MAGIC      = KICK_MAGIC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] csr_a,
  input  logic       csr_we,
  input  logic [7:0] csr_di,
  output logic [7:0] csr_do,
  output logic       wdt_rst_req,
  output logic       irq,
  output logic [1:0] o_dbg_state
);

  wdt_state_e r_state;
  logic       r_en;
  logic       r_lock;
  logic       r_rst_en;
  logic [7:0] r_timeout;
  logic [7:0] r_count;
  logic       r_rst_req;

  // The 9-bit difference makes addresses below BASE borrow into bit 8, so one
  // compare rejects both sides of the window.
  logic [8:0] w_diff;
  logic       w_hit;
  logic [1:0] w_off;
  logic       w_wr_ctrl;
  logic       w_wr_timeout;
  logic       w_kick;
  logic       w_en_nx;
  logic       w_lock_nx;
  logic       w_rst_en_nx;

  assign w_diff       = {1'b0, csr_a} - {1'b0, BASE};
  assign w_hit        = (w_diff[8:2] == 7'd0);
  assign w_off        = w_diff[1:0];
  assign w_wr_ctrl    = csr_we && w_hit && (w_off == OFF_CTRL);
  assign w_wr_timeout = csr_we && w_hit && (w_off == OFF_TIMEOUT);
  assign w_kick       = csr_we && w_hit && (w_off == OFF_KICK) && (csr_di == KICK_MAGIC);

  // Once locked, EN and RST_EN are frozen and LOCK can only stay set.
  assign w_en_nx     = r_lock ? r_en     : csr_di[CTRL_EN];
  assign w_rst_en_nx = r_lock ? r_rst_en : csr_di[CTRL_RST_EN];
  assign w_lock_nx   = r_lock | csr_di[CTRL_LOCK];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_DISABLED;
      r_en      <= 1'b0;
      r_lock    <= 1'b0;
      r_rst_en  <= 1'b0;
      r_timeout <= DEFAULT_TIMEOUT;
      r_count   <= 8'd0;
      r_rst_req <= 1'b0;
    end else begin
      r_rst_req <= 1'b0;
      if (w_wr_ctrl) begin
        r_en     <= w_en_nx;
        r_lock   <= w_lock_nx;
        r_rst_en <= w_rst_en_nx;
      end
      if (w_wr_timeout) begin
        r_timeout <= csr_di;
      end
      unique case (r_state)
        ST_DISABLED: begin
          if (w_wr_ctrl && w_en_nx) begin
            r_state <= ST_RUNNING;
            r_count <= r_timeout;
          end
        end
        ST_RUNNING: begin
          if (w_wr_ctrl && !w_en_nx) begin
            r_state <= ST_DISABLED;
          end else if (w_kick) begin
            r_count <= r_timeout;
          end else if (tick) begin
            if (r_count <= 8'd1) begin
              r_count   <= 8'd0;
              r_state   <= ST_EXPIRED;
              r_rst_req <= r_rst_en;
            end else begin
              r_count <= r_count - 8'd1;
            end
          end
        end
        ST_EXPIRED: begin
          if (w_wr_ctrl && csr_di[CTRL_EXPIRED]) begin
            if (w_en_nx) begin
              r_state <= ST_RUNNING;
              r_count <= r_timeout;
            end else begin
              r_state <= ST_DISABLED;
            end
          end
        end
        default: r_state <= ST_DISABLED;
      endcase
    end
  end

  always_comb begin
    csr_do = 8'h00;
    if (w_hit) begin
      unique case (w_off)
        OFF_CTRL:    csr_do = {(r_state == ST_EXPIRED), 4'b0000, r_rst_en, r_lock, r_en};
        OFF_TIMEOUT: csr_do = r_timeout;
        OFF_KICK:    csr_do = 8'h00;
        OFF_COUNT:   csr_do = r_count;
        default:     csr_do = 8'h00;
      endcase
    end
  end

  assign wdt_rst_req = r_rst_req;
  assign irq         = (r_state == ST_EXPIRED);
  assign o_dbg_state = r_state;

endmodule

// File: doc/sl28_wdt.md
SL28_WDT -- requirements
Module: sl28_wdt

Interface
REQ-001 Parameter BASE, 8'h10, base CSR address; the block decodes BASE+0..BASE+3.
REQ-002 Parameter DEFAULT_TIMEOUT, 8'd30, reset value of TIMEOUT in ticks.
REQ-003 Parameter KICK_MAGIC, 8'h6b, value that must be written to KICK to reload the counter.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tick  input  1  single-cycle timebase strobe, already synchronous to clk.
REQ-007 csr_a  input  8  CSR address from the I2C slave.
REQ-008 csr_we  input  1  single-cycle write strobe.
REQ-009 csr_di  input  8  write data.
REQ-010 csr_do  output  8  read data; combinational; 8'h00 when csr_a is outside BASE..BASE+3.
REQ-011 wdt_rst_req  output  1  one-cycle board-reset request pulse.
REQ-012 irq  output  1  level interrupt; high while the EXPIRED flag is set.

Function
REQ-013 Register map: BASE+0 CTRL (bit0 EN, bit1 LOCK, bit2 RST_EN, bit7 EXPIRED, bits 6:3 read 0); BASE+1 TIMEOUT rw; BASE+2 KICK (write-only, reads 8'h00); BASE+3 COUNT (read-only).
REQ-014 Writes take effect on the clk edge where csr_we=1 and csr_a matches; writes to unmapped offsets and to COUNT are ignored.
REQ-015 The FSM has three states: DISABLED, RUNNING and EXPIRED.
REQ-016 DISABLED->RUNNING on a CTRL write with EN=1; COUNT loads TIMEOUT on the same edge.
REQ-017 RUNNING->DISABLED on a CTRL write with EN=0 only when LOCK=0.
REQ-018 CTRL write with EN=1 while RUNNING does not reload COUNT.
REQ-019 LOCK is set-only: once LOCK=1, writes to EN, LOCK and RST_EN are ignored until rst.
REQ-020 RUNNING: on tick, if COUNT<=1 then COUNT<=0 and the FSM enters EXPIRED; otherwise COUNT<=COUNT-1. TIMEOUT=N therefore expires on the Nth tick, and N=0 behaves as N=1.
REQ-021 RUNNING: a KICK write of KICK_MAGIC reloads COUNT from TIMEOUT; any other KICK value is ignored and does not change COUNT.
REQ-022 A valid kick and a tick in the same cycle: the kick wins, COUNT=TIMEOUT and no decrement occurs.
REQ-023 A TIMEOUT write while RUNNING affects only subsequent reloads; the current COUNT is unchanged.
REQ-024 Entry to EXPIRED sets EXPIRED=1 and, if RST_EN=1, drives wdt_rst_req high for exactly one cycle.
REQ-025 EXPIRED: ticks and kicks are ignored and COUNT holds 0.
REQ-026 EXPIRED is cleared by a CTRL write with bit7=1 (write-1-to-clear); clearing is permitted even when LOCK=1.
REQ-027 On clear, the next state is RUNNING with COUNT reloaded from TIMEOUT if EN=1, else DISABLED.
REQ-028 A CTRL write that clears EXPIRED also applies its EN/RST_EN/LOCK bits, subject to REQ-019; the resulting EN decides REQ-027.
REQ-029 DISABLED: ticks and kicks have no effect; COUNT holds its value.
REQ-030 COUNT arithmetic is 8-bit unsigned and never wraps below 0.

Reset
REQ-031 On rst the block enters DISABLED with EN=0, LOCK=0, RST_EN=0, EXPIRED=0, TIMEOUT=DEFAULT_TIMEOUT, COUNT=0, wdt_rst_req=0, irq=0.
REQ-032 Reset mid-countdown or while EXPIRED abandons the operation without emitting wdt_rst_req.
REQ-033 rst has priority over every simultaneous CSR write or tick.

Structure
REQ-034 The shared package holds the CTRL bit indices, the register offsets (0..3), KICK_MAGIC default and the FSM state encoding.
REQ-035 The block is a single module with no sub-modules; the top level connects it to the I2C slave CSR bus in parallel with the other peripherals, OR-ing the csr_do outputs.

Verification
REQ-036 TIMEOUT=3, write CTRL=8'h05 (EN, RST_EN), apply 3 ticks -> COUNT reads 2, 1, then EXPIRED; wdt_rst_req pulses 1 cycle, irq=1, CTRL reads 8'h85.
REQ-037 RUNNING with COUNT=1, KICK=8'h6b and tick in the same cycle -> COUNT=TIMEOUT and no expiry; KICK=8'h00 leaves COUNT unchanged.
REQ-038 CTRL=8'h03 (EN, LOCK), then CTRL=8'h00 -> CTRL still reads 8'h03 and the counter keeps decrementing on ticks.
REQ-039 EXPIRED with EN=1, write CTRL=8'h81 -> irq drops, state RUNNING, COUNT=TIMEOUT; repeat with CTRL=8'h80 -> DISABLED.
REQ-040 TIMEOUT=0, enable, 1 tick -> EXPIRED; RST_EN=0 -> no wdt_rst_req, irq=1.
REQ-041 Assert rst with COUNT=5 while RUNNING -> all registers at reset values, csr_do reads 8'h00 at BASE+3, no pulse on wdt_rst_req; reads at BASE+4 return 8'h00 throughout.
